// File: rtl/key_conditioner_pkg.sv
// Shared types and helpers for the multi-channel key conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HELD     = 2'd1,
    LONG     = 2'd2
  } key_state_e;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key pins in, conditioned per-key levels and event pulses out.
interface key_conditioner_if #(
  parameter int N_KEYS = 4
);

  logic [N_KEYS-1:0] i_in;
  logic [N_KEYS-1:0] o_level;
  logic [N_KEYS-1:0] o_neg;
  logic [N_KEYS-1:0] o_pos;
  logic [N_KEYS-1:0] o_long;
  logic [N_KEYS-1:0] o_repeat;

  modport master (
    output i_in,
    input  o_level, o_neg, o_pos, o_long, o_repeat
  );

  modport slave (
    input  i_in,
    output o_level, o_neg, o_pos, o_long, o_repeat
  );

endinterface

// File: rtl/key_conditioner_ch.sv
// One key channel: synchroniser, debounce, press/long/repeat state machine.
module key_conditioner_ch
  import key_pkg::*;
#(
  parameter int ACTIVE_LOW    = 1,
  parameter int DEB_CYCLES    = 240000,
  parameter int LONG_CYCLES   = 12000000,
  parameter int REPEAT_CYCLES = 2400000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_level,
  output logic o_neg,
  output logic o_pos,
  output logic o_long,
  output logic o_repeat
);

  localparam int DEB_W  = cnt_width(DEB_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_CYCLES);
  localparam int REP_W  = cnt_width(REPEAT_CYCLES);

  localparam logic              REL_PIN   = (ACTIVE_LOW != 0);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  // Hold counting starts at press acceptance, DEB_CYCLES+2 after the raw edge.
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
  localparam logic              REP_EN    = (REPEAT_CYCLES != 0);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

  logic              sync1_reg, sync2_reg;
  logic              level_reg, level_next;
  logic [DEB_W-1:0]  deb_cnt_reg, deb_cnt_next;
  key_state_e        state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [REP_W-1:0]  rep_cnt_reg, rep_cnt_next;
  logic              neg_reg, pos_reg, long_reg, repeat_reg;
  logic              neg_next, pos_next, long_next, repeat_next;
  logic              pressed, differ, flip, press_acc, rel_acc;

  assign pressed   = (sync2_reg != REL_PIN);
  assign differ    = (pressed != level_reg);
  assign flip      = differ && (deb_cnt_reg == DEB_LAST);
  assign press_acc = flip && pressed;
  assign rel_acc   = flip && !pressed;

  always_comb begin
    deb_cnt_next = (!differ || flip) ? '0 : deb_cnt_reg + DEB_W'(1);
    level_next   = flip ? pressed : level_reg;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_reg    <= REL_PIN;
      sync2_reg    <= REL_PIN;
      level_reg    <= 1'b0;
      deb_cnt_reg  <= '0;
      state_reg    <= RELEASED;
      hold_cnt_reg <= '0;
      rep_cnt_reg  <= '0;
      neg_reg      <= 1'b0;
      pos_reg      <= 1'b0;
      long_reg     <= 1'b0;
      repeat_reg   <= 1'b0;
    end else begin
      sync1_reg    <= i_in;
      sync2_reg    <= sync1_reg;
      level_reg    <= level_next;
      deb_cnt_reg  <= deb_cnt_next;
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      rep_cnt_reg  <= rep_cnt_next;
      neg_reg      <= neg_next;
      pos_reg      <= pos_next;
      long_reg     <= long_next;
      repeat_reg   <= repeat_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = '0;
    rep_cnt_next  = '0;
    case (state_reg)
      RELEASED: begin
        if (press_acc) state_next = HELD;
      end
      HELD: begin
        if (rel_acc) begin
          state_next = RELEASED;
        end else if (hold_cnt_reg == LONG_LAST) begin
          state_next = LONG;
        end else begin
          hold_cnt_next = (hold_cnt_reg == HOLD_MAX) ? hold_cnt_reg : hold_cnt_reg + HOLD_W'(1);
        end
      end
      LONG: begin
        if (rel_acc) begin
          state_next = RELEASED;
        end else if (REP_EN && rep_cnt_reg != REP_LAST) begin
          rep_cnt_next = rep_cnt_reg + REP_W'(1);
        end
      end
      default: state_next = RELEASED;
    endcase
  end

  // A release accepted this cycle suppresses any long/repeat pulse.
  always_comb begin
    neg_next    = press_acc;
    pos_next    = rel_acc;
    long_next   = 1'b0;
    repeat_next = 1'b0;
    if (state_reg == HELD && !rel_acc && hold_cnt_reg == LONG_LAST)
      long_next = 1'b1;
    if (REP_EN && state_reg == LONG && !rel_acc && rep_cnt_reg == REP_LAST)
      repeat_next = 1'b1;
  end

  assign o_level  = level_reg;
  assign o_neg    = neg_reg;
  assign o_pos    = pos_reg;
  assign o_long   = long_reg;
  assign o_repeat = repeat_reg;

endmodule

// File: rtl/key_conditioner.sv
// N independent key channels behind one conditioner interface.
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DEB_CYCLES    = 240000,
  parameter int LONG_CYCLES   = 12000000,
  parameter int REPEAT_CYCLES = 2400000
) (
  input logic         i_clk,
  input logic         i_rst_n,
  key_conditioner_if.slave bus
);

  logic [N_KEYS-1:0] level_w, neg_w, pos_w, long_w, repeat_w;

  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
      key_conditioner_ch #(
        .ACTIVE_LOW    (ACTIVE_LOW),
        .DEB_CYCLES    (DEB_CYCLES),
        .LONG_CYCLES   (LONG_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
      ) u_ch (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_in     (bus.i_in[gi]),
        .o_level  (level_w[gi]),
        .o_neg    (neg_w[gi]),
        .o_pos    (pos_w[gi]),
        .o_long   (long_w[gi]),
        .o_repeat (repeat_w[gi])
      );
    end
  endgenerate

  assign bus.o_level  = level_w;
  assign bus.o_neg    = neg_w;
  assign bus.o_pos    = pos_w;
  assign bus.o_long   = long_w;
  assign bus.o_repeat = repeat_w;

endmodule

// File: tb/tb_key_conditioner.sv
// Two conditioners (repeat on / repeat off) driven by the same pins and
// compared every cycle against a window/timestamp reference model.
module tb_key_conditioner;

  localparam int N     = 2;
  localparam int DEB   = 4;
  localparam int LONGC = 20;
  localparam int REP   = 8;
  localparam int NCYC  = 3000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] pins = '1;

  always #5 clk = ~clk;

  key_conditioner_if #(.N_KEYS(N)) bus_a ();
  key_conditioner_if #(.N_KEYS(N)) bus_b ();

  assign bus_a.i_in = pins;
  assign bus_b.i_in = pins;

  key_conditioner #(
    .N_KEYS(N), .ACTIVE_LOW(1), .DEB_CYCLES(DEB), .LONG_CYCLES(LONGC), .REPEAT_CYCLES(REP)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a)
  );

  key_conditioner #(
    .N_KEYS(N), .ACTIVE_LOW(1), .DEB_CYCLES(DEB), .LONG_CYCLES(LONGC), .REPEAT_CYCLES(0)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b)
  );

  logic [N-1:0] pin_hist [NCYC];
  bit           rst_hist [NCYC];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;

  bit           lvl [N];
  int           press_t [N];
  logic [N-1:0] e_level, e_neg, e_pos, e_long, e_rep_a;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Pressed state seen by the debouncer in cycle k (two-flop delay, reset forces released).
  function automatic bit samp(input int ch, input int k);
    if (k < 2) return 1'b0;
    if (rst_hist[k] || rst_hist[k-1] || rst_hist[k-2]) return 1'b0;
    return (pin_hist[k-2][ch] == 1'b0);
  endfunction

  task automatic model_step(input int t);
    bit flip;
    int d;
    e_neg = '0; e_pos = '0; e_long = '0; e_rep_a = '0;
    for (int ch = 0; ch < N; ch++) begin
      if (t == 0 || rst_hist[t] || rst_hist[t-1]) begin
        lvl[ch] = 1'b0;
      end else begin
        flip = 1'b1;
        for (int k = t - DEB; k < t; k++)
          if (samp(ch, k) == lvl[ch]) flip = 1'b0;
        if (flip) begin
          if (!lvl[ch]) e_neg[ch] = 1'b1;
          else          e_pos[ch] = 1'b1;
          lvl[ch] = !lvl[ch];
          if (lvl[ch]) press_t[ch] = t;
        end else if (lvl[ch]) begin
          d = t - press_t[ch];
          if (d == LONGC - DEB) e_long[ch] = 1'b1;
          if (d > LONGC - DEB && ((d - (LONGC - DEB)) % REP) == 0) e_rep_a[ch] = 1'b1;
        end
      end
      e_level[ch] = lvl[ch];
    end
  endtask

  task automatic press(input int ch, input int from, input int to);
    for (int t = from; t <= to; t++) pin_hist[t][ch] = 1'b0;
  endtask

  initial begin
    int rem [N];
    bit val [N];
    int s;

    for (int t = 0; t < NCYC; t++) begin
      pin_hist[t] = '1;
      rst_hist[t] = (t < 3);
    end
    press(0, 10, 19);
    press(1, 40, 42);
    press(0, 60, 109);
    press(0, 140, 199);
    rst_hist[165] = 1'b1;
    rst_hist[166] = 1'b1;
    press(0, 220, 259);
    press(1, 220, 231);

    for (int ch = 0; ch < N; ch++) begin
      rem[ch] = 0;
      val[ch] = 1'b1;
      press_t[ch] = 0;
      lvl[ch] = 1'b0;
    end
    for (int t = 300; t < NCYC - 60; t++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (rem[ch] == 0) begin
          val[ch] = 1'($urandom_range(0, 1));
          rem[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DEB + 1))
                                                : int'($urandom_range(DEB, 45));
        end
        pin_hist[t][ch] = val[ch];
        rem[ch]--;
      end
    end
    for (int r = 0; r < 4; r++) begin
      s = int'($urandom_range(400, NCYC - 100));
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) rst_hist[s + k] = 1'b1;
    end

    for (int t = 0; t < NCYC; t++) begin
      @(posedge clk);
      #1;
      cyc   = t;
      pins  = pin_hist[t];
      rst_n = !rst_hist[t];
      model_step(t);
      @(negedge clk);

      check_eq("a_level",  32'(bus_a.o_level),  32'(e_level));
      check_eq("a_neg",    32'(bus_a.o_neg),    32'(e_neg));
      check_eq("a_pos",    32'(bus_a.o_pos),    32'(e_pos));
      check_eq("a_long",   32'(bus_a.o_long),   32'(e_long));
      check_eq("a_repeat", 32'(bus_a.o_repeat), 32'(e_rep_a));
      check_eq("b_level",  32'(bus_b.o_level),  32'(e_level));
      check_eq("b_neg",    32'(bus_b.o_neg),    32'(e_neg));
      check_eq("b_pos",    32'(bus_b.o_pos),    32'(e_pos));
      check_eq("b_long",   32'(bus_b.o_long),   32'(e_long));
      check_eq("b_repeat", 32'(bus_b.o_repeat), 32'(0));

      case (t)
        16:  check_eq("plan_neg0",     32'(bus_a.o_neg),    32'h1);
        26:  check_eq("plan_pos0",     32'(bus_a.o_pos),    32'h1);
        82:  check_eq("plan_long0",    32'(bus_a.o_long),   32'h1);
        90:  check_eq("plan_rep0",     32'(bus_a.o_repeat), 32'h1);
        106: check_eq("plan_rep2",     32'(bus_a.o_repeat), 32'h1);
        116: check_eq("plan_pos_long", 32'(bus_a.o_pos),    32'h1);
        166: check_eq("plan_rst_lvl",  32'(bus_a.o_level),  32'h0);
        173: check_eq("plan_neg_rst",  32'(bus_a.o_neg),    32'h1);
        226: check_eq("plan_neg_both", 32'(bus_a.o_neg),    32'h3);
        238: check_eq("plan_pos1",     32'(bus_a.o_pos),    32'h2);
        242: check_eq("plan_long_ch0", 32'(bus_a.o_long),   32'h1);
        266: check_eq("plan_rel_wins", 32'(bus_a.o_repeat), 32'h0);
        default: ;
      endcase

      if ((e_neg | e_pos | e_long | e_rep_a) != '0)
        $display("cyc=%0d pins=%b level=%b neg=%b pos=%b long=%b rep=%b",
                 t, pin_hist[t], e_level, e_neg, e_pos, e_long, e_rep_a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Parametrised multi-channel push-button conditioner: the next generation of the per-key debouncer used for the board keys. It synchronises N raw key inputs, debounces each with a programmable window and produces press/release pulses. It adds long-press detection and auto-repeat, which the single-channel debouncer lacks. It sits between the board KEY/SW pins and the `top` control logic, in the same clock domain as the logic consuming its pulses.

## Interface
- `N_KEYS`, 4: number of independent channels.
- `ACTIVE_LOW`, 1: 1 = pressed is pin level 0 (board keys); 0 = pressed is level 1.
- `DEB_CYCLES`, 240000: consecutive stable cycles required to accept a level change; must be ≥1.
- `LONG_CYCLES`, 12000000: cycles after press acceptance until the long-press pulse; must be > `DEB_CYCLES`.
- `REPEAT_CYCLES`, 2400000: auto-repeat period after the long pulse; 0 disables repeat.
- `i_clk`  in  1: sole clock.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_in`  in  N_KEYS: raw asynchronous key pins.
- `o_level`  out  N_KEYS: debounced state; 1 = pressed.
- `o_neg`  out  N_KEYS: one-cycle pulse on accepted press.
- `o_pos`  out  N_KEYS: one-cycle pulse on accepted release.
- `o_long`  out  N_KEYS: one-cycle pulse at long-press threshold.
- `o_repeat`  out  N_KEYS: one-cycle pulse each repeat period while held past long threshold.

## Operation
- Channels are fully independent; no cross-channel interaction.
- Per channel: 2-flop synchroniser, then normalise to "pressed = 1" per `ACTIVE_LOW`.
- Debounce counter `deb_cnt`, width $clog2(DEB_CYCLES+1). It increments while the synchronised value ≠ `o_level`, and clears to 0 on any cycle it equals `o_level`. When it would reach `DEB_CYCLES`, `o_level` flips and the counter clears.
- Per-channel FSM (states in package): RELEASED, HELD, LONG.
  - RELEASED → HELD on accepted press; `o_neg`=1 that cycle; hold counter cleared.
  - HELD: hold counter increments each cycle. At count `LONG_CYCLES-DEB_CYCLES`, `o_long`=1 and → LONG. Accepted release → RELEASED with `o_pos`=1 and no `o_long`.
  - LONG: repeat counter runs. Each `REPEAT_CYCLES` cycles, `o_repeat`=1 and the counter wraps to 0. With `REPEAT_CYCLES`=0, no `o_repeat` is ever produced. Accepted release → RELEASED, `o_pos`=1.
- Hold counter saturates and never wraps. Hold width is $clog2(LONG_CYCLES+1); repeat width is $clog2(REPEAT_CYCLES+1), minimum 1.
- Glitches shorter than `DEB_CYCLES` produce no output activity.
- Reset (any time, including mid-press): synchroniser flops load the released pin level, counters clear, FSM → RELEASED, all outputs 0. A key still held after reset release is treated as a fresh press after full debounce. No `o_pos` is emitted for a press interrupted by reset.

## Timing
- All outputs are registered; reset value of every output is 0.
- A clean input edge at cycle 0 (sampled at the first `i_clk` edge) produces the `o_level` change and the `o_neg`/`o_pos` pulse at cycle `DEB_CYCLES+2`.
- `o_long` fires exactly `LONG_CYCLES+2` cycles after the raw press edge.
- First `o_repeat` fires `REPEAT_CYCLES` cycles after `o_long`; subsequent ones follow every `REPEAT_CYCLES` cycles.
- `o_neg`, `o_pos`, `o_long` and `o_repeat` are mutually exclusive per channel in any cycle.
- Release accepted in the same cycle a long or repeat would fire: release wins. `o_pos`=1 and the long/repeat pulse is suppressed.

## Structure
- `key_pkg`: FSM state enum `key_state_e` (RELEASED, HELD, LONG) and a width helper function for counter widths.
- Sub-module `key_conditioner_ch`: one channel (synchroniser, debounce, FSM, counters). The top is a generate loop over `N_KEYS` instances.

## Test plan
Bench parameters: N_KEYS=2, DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1.
- Clean press on ch0 at cycle 10, held 10 cycles → `o_neg[0]` pulse at cycle 16, `o_level[0]`=1 from 16; release → `o_pos[0]` 6 cycles after the release edge; no `o_long`.
- 3-cycle low glitch on ch1 → no pulses; `o_level[1]` stays 0.
- Hold ch0 from cycle 0 for 50 cycles → `o_long` at 22, `o_repeat` at 30, 38, 46; `o_pos` at 56.
- REPEAT_CYCLES=0 rebuild, hold 60 cycles → single `o_long`, zero `o_repeat`.
- Assert `i_rst_n` at cycle 25 during a held key, deassert at 27 with key still held → outputs 0 immediately, no `o_pos`; `o_neg` at 33.
- Simultaneous press on both channels, ch1 released at cycle 12 → ch0 `o_long` unaffected at 22; ch1 shows only `o_neg` and `o_pos`.
